// File: rtl/req_encoder_32to5.sv
// Latches request lines into a pending vector and hands out one 5-bit index at a time; fixed-priority or round-robin pick.
// Req->Valid takes 2 edges; Out/Valid hold until Ack; one idle cycle between grants; pending keeps accumulating while E=0.
module req_encoder_32to5 #(
  parameter bit RR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic        e,
  input  logic        ack,
  output logic [4:0]  out,
  output logic        valid,
  output logic [31:0] pending,
  output logic        any
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [4:0]  sel;
  logic [4:0]  idx;
  logic        found;
  logic [31:0] clr;

  assign any = |pending;

  // Only a completed handshake clears; a fresh request on the same bit re-sets it.
  assign clr = (valid && ack) ? (32'd1 << out) : 32'd0;

  // Scan starts at ptr in round-robin mode (5-bit wrap), at 0 otherwise.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idx = RR ? (ptr + 5'(i)) : 5'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      out     <= '0;
      valid   <= 1'b0;
      ptr     <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
      case (state)
        IDLE: begin
          if (e && any) begin
            out   <= sel;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
            if (RR) ptr <= out + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Drives a fixed-priority and a round-robin encoder with shared stimulus and
// checks both against a per-edge reference model of the pending/grant rules.
module tb_req_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req = '0;
  logic        e = 1'b0;
  logic        ack = 1'b0;

  logic [4:0]  out_w   [2];
  logic        valid_w [2];
  logic [31:0] pend_w  [2];
  logic        any_w   [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pend  [2];
  bit          m_valid [2];
  int          m_out   [2];
  int          m_ptr   [2];

  always #5 clk = ~clk;

  req_encoder_32to5 #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .e(e), .ack(ack),
    .out(out_w[0]), .valid(valid_w[0]), .pending(pend_w[0]), .any(any_w[0])
  );

  req_encoder_32to5 #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .e(e), .ack(ack),
    .out(out_w[1]), .valid(valid_w[1]), .pending(pend_w[1]), .any(any_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner = set bit with smallest distance from the start point (0, or ptr in RR mode).
  function automatic int pick(input logic [31:0] p, input int ptr, input bit rr);
    int best = 0;
    int best_key = 99;
    int key;
    for (int i = 0; i < 32; i++) begin
      if (p[i]) begin
        key = rr ? ((i - ptr + 32) % 32) : i;
        if (key < best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_valid[m] = 1'b0;
      m_out[m]   = 0;
      m_ptr[m]   = 0;
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("valid%0d", m), 32'(valid_w[m]), 32'(m_valid[m]));
      check($sformatf("out%0d", m), 32'(out_w[m]), 32'(m_out[m]));
      check($sformatf("pending%0d", m), pend_w[m], m_pend[m]);
      check($sformatf("any%0d", m), 32'(any_w[m]), 32'(m_pend[m] != 0));
    end
  endtask

  task automatic step();
    logic [31:0] clr;
    logic [31:0] np;
    @(posedge clk);
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        clr = (m_valid[m] && ack) ? (32'd1 << m_out[m]) : 32'd0;
        np  = (m_pend[m] & ~clr) | req;
        if (!m_valid[m]) begin
          if (e && m_pend[m] != 0) begin
            m_out[m]   = pick(m_pend[m], m_ptr[m], m == 1);
            m_valid[m] = 1'b1;
          end
        end else if (ack) begin
          m_valid[m] = 1'b0;
          if (m == 1) m_ptr[m] = (m_out[m] + 1) % 32;
        end
        m_pend[m] = np;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic [31:0] req_during);
    rst_n = 1'b0;
    req   = req_during;
    ack   = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int i = 0; i < 3; i++) step();
    req   = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int budget;

    // Reset with every request line high: nothing may leak through.
    do_reset(32'hFFFF_FFFF);
    check("rst_valid", 32'(valid_w[0]), 32'd0);
    check("rst_pending", pend_w[1], 32'd0);

    // Two requests, fixed priority: 4 then 8.
    e = 1'b1;
    req = 32'h0000_0110; step();
    req = '0;            step();
    check("t2_valid", 32'(valid_w[0]), 32'd1);
    check("t2_out_a", 32'(out_w[0]), 32'd4);
    ack = 1'b1; step();
    ack = 1'b0;
    check("t2_bubble", 32'(valid_w[0]), 32'd0);
    step();
    check("t2_out_b", 32'(out_w[0]), 32'd8);
    ack = 1'b1; step();
    ack = 1'b0;
    check("t2_done_valid", 32'(valid_w[0]), 32'd0);
    check("t2_done_any", 32'(any_w[0]), 32'd0);

    // Ack and a new request for the same index on the same edge.
    do_reset('0);
    e = 1'b1;
    req = 32'd1 << 5; step();
    req = '0;         step();
    check("t3_out", 32'(out_w[0]), 32'd5);
    ack = 1'b1; req = 32'd1 << 5; step();
    ack = 1'b0; req = '0;
    check("t3_pend5", 32'(pend_w[0][5]), 32'd1);
    step();
    check("t3_revalid", 32'(valid_w[0]), 32'd1);
    check("t3_reout", 32'(out_w[0]), 32'd5);
    ack = 1'b1; step(); ack = 1'b0;

    // Enable low: pending accumulates, no grant until enabled.
    do_reset('0);
    e = 1'b0;
    req = 32'h8000_0000; step();
    req = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_valid", 32'(valid_w[0]), 32'd0);
    end
    check("t4_pending", pend_w[0], 32'h8000_0000);
    e = 1'b1; step();
    check("t4_valid", 32'(valid_w[0]), 32'd1);
    check("t4_out", 32'(out_w[0]), 32'd31);
    ack = 1'b1; step(); ack = 1'b0;

    // Round-robin with all requests held: 0..31 then wrap to 0,1.
    do_reset('0);
    e = 1'b1;
    req = 32'hFFFF_FFFF;
    grants = 0;
    budget = 0;
    while (grants < 34 && budget < 300) begin
      step();
      budget++;
      if (valid_w[1]) begin
        check("t5_rr_seq", 32'(out_w[1]), 32'(grants % 32));
        grants++;
        ack = 1'b1; step(); ack = 1'b0;
        budget++;
      end
    end
    check("t5_grants", 32'(grants), 32'd34);
    req = '0;

    // Asynchronous reset mid-handshake.
    do_reset('0);
    e = 1'b1;
    req = 32'd1 << 3; step();
    req = '0;         step();
    check("t6_out", 32'(out_w[1]), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid", 32'(valid_w[1]), 32'd0);
    check("t6_async_pend", pend_w[1], 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("t6_no_spurious", 32'(valid_w[0]) | 32'(valid_w[1]), 32'd0);

    // Randomised traffic with occasional asynchronous resets.
    do_reset('0);
    for (int c = 0; c < 1500; c++) begin
      req = (($urandom % 4) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
      e   = ($urandom % 8) != 0;
      ack = $urandom % 2;
      if (($urandom % 250) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
